stone_render: RTL and testbench

STONE_RENDER -- requirements
Module: stone_render

---
 rtl/stone_render_if.sv | 33 +++
 rtl/stone_render.sv | 189 ++++++++++++++++++
 tb/tb_stone_render.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stone_render_if.sv
// ============================================================================
//  Module      : stone_render_if
//  Description : Frame-draw control, object-RAM read and VGA pixel signals
//                shared between the stone renderer and its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stone_render_if;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] ram_data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, quantity, ram_data,
        input  draw_stone_flag, draw_index, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        input  start, quantity, ram_data,
        output draw_stone_flag, draw_index, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/stone_render.sv
// ============================================================================
//  Module      : stone_render
//  Description : Walks the object RAM and rasterises every visible stone as a
//                clipped 16x16 block of pixels for the VGA adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stone_render (
    input  wire logic        clock,
    input  wire logic        resetn,
    stone_render_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ADDR  = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RD_LATCH = 3'd3,
        S_CHECK    = 3'd4,
        S_DRAW     = 3'd5,
        S_NEXT     = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    localparam logic [9:0] c_SCREEN_W = 10'd320;
    localparam logic [9:0] c_SCREEN_H = 10'd240;

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_qty;
    logic [3:0]  r_dx;
    logic [3:0]  r_dy;
    logic [31:0] r_stone;

    logic        r_flag;
    logic [3:0]  r_index;
    logic [8:0]  r_vga_x;
    logic [7:0]  r_vga_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_busy;
    logic        r_done;

    logic [3:0]  w_dx_n;
    logic [3:0]  w_dy_n;
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic        w_on;
    logic [2:0]  w_colour;
    logic [3:0]  w_idx_inc;
    logic        w_unused;

    // Coordinates of the pixel to be shown next cycle: origin when leaving
    // CHECK, otherwise the row-major successor of the current one.
    always_comb begin
        w_dx_n = 4'd0;
        w_dy_n = 4'd0;
        if (r_state == S_DRAW) begin
            w_dx_n = r_dx + 4'd1;
            w_dy_n = (r_dx == 4'hF) ? r_dy + 4'd1 : r_dy;
        end
    end

    assign w_px      = {1'b0, r_stone[31:23]} + {6'd0, w_dx_n};
    assign w_py      = {2'd0, r_stone[18:11]} + {6'd0, w_dy_n};
    assign w_on      = (w_px < c_SCREEN_W) && (w_py < c_SCREEN_H);
    assign w_idx_inc = r_idx + 4'd1;
    assign w_unused  = &{1'b0, r_stone[22:19], r_stone[10:4], r_stone[0]};

    always_comb begin
        w_colour = 3'b111;
        case (r_stone[3:2])
            2'b00:   w_colour = 3'b111;
            2'b01:   w_colour = 3'b110;
            2'b10:   w_colour = 3'b011;
            default: w_colour = 3'b101;
        endcase
    end

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_idx    <= 4'd0;
            r_qty    <= 4'd0;
            r_dx     <= 4'd0;
            r_dy     <= 4'd0;
            r_stone  <= 32'd0;
            r_flag   <= 1'b0;
            r_index  <= 4'd0;
            r_vga_x  <= 9'd0;
            r_vga_y  <= 8'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.quantity == 4'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_qty   <= bus.quantity;
                            r_idx   <= 4'd0;
                            r_state <= S_RD_ADDR;
                            r_flag  <= 1'b1;
                            r_index <= 4'd0;
                        end
                    end
                end
                S_RD_ADDR: r_state <= S_RD_WAIT;
                S_RD_WAIT: r_state <= S_RD_LATCH;
                S_RD_LATCH: begin
                    r_stone <= bus.ram_data;
                    r_state <= S_CHECK;
                    r_flag  <= 1'b0;
                    r_index <= 4'd0;
                end
                S_CHECK: begin
                    if (r_stone[1]) begin
                        r_state  <= S_DRAW;
                        r_dx     <= 4'd0;
                        r_dy     <= 4'd0;
                        r_plot   <= w_on;
                        r_vga_x  <= w_px[8:0];
                        r_vga_y  <= w_py[7:0];
                        r_colour <= w_colour;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (r_dx == 4'hF && r_dy == 4'hF) begin
                        r_state  <= S_NEXT;
                        r_plot   <= 1'b0;
                        r_vga_x  <= 9'd0;
                        r_vga_y  <= 8'd0;
                        r_colour <= 3'd0;
                    end else begin
                        r_dx     <= w_dx_n;
                        r_dy     <= w_dy_n;
                        r_plot   <= w_on;
                        r_vga_x  <= w_px[8:0];
                        r_vga_y  <= w_py[7:0];
                        r_colour <= w_colour;
                    end
                end
                S_NEXT: begin
                    r_idx <= w_idx_inc;
                    if (w_idx_inc == r_qty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD_ADDR;
                        r_flag  <= 1'b1;
                        r_index <= w_idx_inc;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_flag  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.draw_stone_flag = r_flag;
    assign bus.draw_index      = r_index;
    assign bus.vga_x           = r_vga_x;
    assign bus.vga_y           = r_vga_y;
    assign bus.vga_colour      = r_colour;
    assign bus.plot            = r_plot;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_stone_render.sv
// ============================================================================
//  Module      : tb_stone_render
//  Description : Scoreboard bench for stone_render with a 1-cycle object RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stone_render;

    localparam int K_FLAG = 0;
    localparam int K_PLOT = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] ram_q = 32'd0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          plot_cnt = 0;
    ev_t         exp_q [$];

    stone_render_if bus ();

    stone_render dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    always @(posedge clock) ram_q <= mem[bus.draw_index];
    assign bus.ram_data = ram_q;

    function automatic logic [31:0] mk(input int x, input int y, input int ty,
                                       input int vis, input int mov);
        logic [8:0] xv;
        logic [7:0] yv;
        logic [1:0] tv;
        xv = x[8:0];
        yv = y[7:0];
        tv = ty[1:0];
        return {xv, 4'b0, yv, 7'b0, tv, vis[0], mov[0]};
    endfunction

    function automatic int colour_of(input logic [1:0] ty);
        case (ty)
            2'b00:   return 7;
            2'b01:   return 6;
            2'b10:   return 3;
            default: return 5;
        endcase
    endfunction

    task automatic push_ev(input int k, input int t, input int a, input int b, input int c);
        ev_t e;
        e.kind = k; e.cyc = t; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
    endtask

    // Expected event stream for a pass whose start is sampled in cycle s.
    task automatic push_model(input int qty, input int s, input int lat);
        int t;
        logic [31:0] w;
        int x, y, col;
        t = s + 1;
        for (int i = 0; i < qty; i++) begin
            w = mem[i];
            for (int k = 0; k < 3; k++) push_ev(K_FLAG, t + k, i, 0, 0);
            if (w[1]) begin
                x = int'(w[31:23]);
                y = int'(w[18:11]);
                col = colour_of(w[3:2]);
                for (int dy = 0; dy < 16; dy++)
                    for (int dx = 0; dx < 16; dx++)
                        if (x + dx < 320 && y + dy < 240)
                            push_ev(K_PLOT, t + 4 + dy * 16 + dx, x + dx, y + dy, col);
                t += 261;
            end else begin
                t += 5;
            end
        end
        push_ev(K_DONE, s + lat, 0, 0, 0);
    endtask

    task automatic chk_ev(input int k, input int a, input int b, input int c);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%0d b=%0d c=%0d, expected no event",
                     k, cyc, a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.a != a || e.b != b || e.c != c) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d a=%0d b=%0d c=%0d, expected kind=%0d cyc=%0d a=%0d b=%0d c=%0d",
                         k, cyc, a, b, c, e.kind, e.cyc, e.a, e.b, e.c);
            end
        end
    endtask

    always @(negedge clock) begin
        if (bus.draw_stone_flag) chk_ev(K_FLAG, int'(bus.draw_index), 0, 0);
        if (bus.plot) begin
            plot_cnt++;
            chk_ev(K_PLOT, int'(bus.vga_x), int'(bus.vga_y), int'(bus.vga_colour));
        end
        if (bus.done) chk_ev(K_DONE, 0, 0, 0);
    end

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_quiet(input string name);
        check_val(name, int'({bus.busy, bus.done, bus.draw_stone_flag, bus.draw_index,
                              bus.plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    endtask

    // mode 0: plain pass; 1: re-pulse start (new quantity) mid-DRAW;
    // 2: reset mid-DRAW, no completion expected.
    task automatic run_pass(input string name, input int qty, input int exp_plots,
                            input int lat, input int mode);
        int s;
        plot_cnt = 0;
        @(negedge clock);
        s = cyc;
        push_model(qty, s, lat);
        bus.quantity = qty[3:0];
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        bus.quantity = 4'd9;
        check_val({name, "_busy"}, int'(bus.busy), 1);
        if (mode == 1) begin
            repeat (100) @(negedge clock);
            bus.start = 1'b1;
            bus.quantity = 4'd7;
            @(negedge clock);
            bus.start = 1'b0;
        end
        if (mode == 2) begin
            repeat (50) @(negedge clock);
            #1;
            resetn = 1'b0;
            exp_q.delete();
            @(posedge clock);
            #1;
            check_quiet({name, "_reset_outputs"});
            @(negedge clock);
            resetn = 1'b1;
            return;
        end
        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(negedge clock);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (6) @(negedge clock);
        check_val({name, "_plot_count"}, plot_cnt, exp_plots);
        check_val({name, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.quantity = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset_state");
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check_quiet("idle_after_reset");

        mem[0] = mk(10, 20, 1, 1, 0);
        run_pass("single_gold", 1, 256, 262, 0);

        mem[0] = mk(0, 0, 0, 1, 1);
        mem[1] = mk(50, 60, 2, 0, 0);
        mem[2] = mk(100, 50, 2, 1, 0);
        run_pass("three_entries", 3, 512, 528, 0);

        mem[0] = mk(310, 230, 3, 1, 0);
        run_pass("clipped_corner", 1, 100, 262, 0);

        run_pass("zero_quantity", 0, 0, 1, 0);

        mem[0] = mk(200, 100, 0, 1, 0);
        run_pass("restart_ignored", 1, 256, 262, 1);

        mem[0] = mk(10, 20, 1, 1, 0);
        run_pass("reset_mid_draw", 1, 0, 262, 2);
        repeat (3) @(negedge clock);
        check_quiet("post_abort_idle");

        mem[0] = mk(0, 0, 0, 1, 1);
        mem[1] = mk(50, 60, 2, 0, 0);
        mem[2] = mk(100, 50, 2, 1, 0);
        run_pass("after_abort", 3, 512, 528, 0);

        for (int i = 3; i < 15; i++) mem[i] = mk(i * 10, i * 5, 1, 0, 0);
        mem[15] = mk(5, 5, 0, 1, 0);
        run_pass("max_quantity", 15, 512, 588, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
